// File: rtl/dc_axi_pattern_read_slave_if.sv
// AXI4 read-address and read-data channel bundle between a read master and slave.
// No logic; signals only.
// Valid/ready handshakes on both channels; ar* flows to the slave, r* flows back.
interface dc_axi_pattern_read_slave_if #(
    parameter int AW = 32,
    parameter int DW = 16,
    parameter int IW = 8
);
    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/dc_axi_pattern_read_slave.sv
// Read-only AXI4 slave returning address-derived pattern data for frame-fetch bursts.
// Latency: FIRST_BEAT_LATENCY cycles from request pop to first rvalid, then one beat per accepted cycle.
// Backpressure: R beats hold while rready=0; AR is refused when the request queue is full or en=0.
module dc_axi_pattern_read_slave #(
    parameter int AXI_ARADDR_WIDTH   = 32,
    parameter int AXI_DATA_WIDTH     = 16,
    parameter int AXI_ID_WIDTH       = 8,
    parameter int AR_QUEUE_DEPTH     = 2,
    parameter int FIRST_BEAT_LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        en,
    input  logic [1:0]                  pattern_mode,
    dc_axi_pattern_read_slave_if.slave  axi,
    output logic                        busy,
    output logic [15:0]                 bursts_done
);
    localparam int AW = AXI_ARADDR_WIDTH;
    localparam int DW = AXI_DATA_WIDTH;
    localparam int IW = AXI_ID_WIDTH;
    localparam int PW = (AR_QUEUE_DEPTH > 1) ? $clog2(AR_QUEUE_DEPTH) : 1;
    localparam int CW = $clog2(AR_QUEUE_DEPTH + 1);

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
    } req_t;

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    req_t          fifo_mem [AR_QUEUE_DEPTH];
    req_t          wreq;
    req_t          head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_empty, fifo_full;
    logic          push, pop, hs, run;

    state_t        state;
    logic [3:0]    lat_cnt;
    logic [7:0]    beat, cur_len;
    logic [7:0]    beat_nxt;
    logic [AW-1:0] cur_addr, addr_nxt;
    logic [2:0]    cur_size;
    logic [1:0]    cur_burst;
    logic          cur_err, head_err;
    logic [IW-1:0] rid_q;
    logic [DW-1:0] rdata_q;
    logic [1:0]    rresp_q;
    logic          rlast_q, rvalid_q;

    // Unsupported burst type or a beat wider than the data bus.
    function automatic logic req_err(input logic [2:0] sz, input logic [1:0] bu);
        return (bu == 2'b11) || ((32'd1 << sz) > 32'(DW / 8));
    endfunction

    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input logic [7:0] b,
                                                 input logic e, input logic [1:0] m);
        logic [DW-1:0] w;
        logic [DW-1:0] d;
        w = a[DW:1];
        case (m)
            2'd0:    d = w;
            2'd1:    d = ~w;
            2'd2:    d = DW'(b);
            default: d = '0;
        endcase
        return e ? '0 : d;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(AR_QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wreq       = '{axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst};
    assign head       = fifo_mem[rd_ptr];
    assign head_err   = req_err(head.size, head.burst);
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CW'(AR_QUEUE_DEPTH));
    // run keeps arready low until the first clock after reset release.
    assign axi.arready = run & en & ~fifo_full;
    assign push       = axi.arvalid & axi.arready;
    assign hs         = rvalid_q & axi.rready;
    // Pop when idle, or back-to-back on the final beat handshake of the active burst.
    assign pop        = ~fifo_empty & ((state == IDLE) | ((state == BURST) & hs & rlast_q));
    assign busy       = ~fifo_empty | (state != IDLE);
    assign beat_nxt   = beat + 8'd1;
    // FIXED holds the address; INCR and WRAP both step by the beat size.
    assign addr_nxt   = (cur_burst == 2'b00) ? cur_addr : cur_addr + (AW'(1) << cur_size);

    assign axi.rid    = rid_q;
    assign axi.rdata  = rdata_q;
    assign axi.rresp  = rresp_q;
    assign axi.rlast  = rlast_q;
    assign axi.rvalid = rvalid_q;

    // Flags the first cycle after reset release.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) run <= 1'b0;
        else       run <= 1'b1;
    end

    // Request queue pointers and occupancy.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push & ~pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (pop & ~push) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    // Request queue storage; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= wreq;
    end

    // Burst sequencer with registered R-channel outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            beat        <= '0;
            cur_len     <= '0;
            cur_addr    <= '0;
            cur_size    <= '0;
            cur_burst   <= '0;
            cur_err     <= 1'b0;
            rid_q       <= '0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            rlast_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            bursts_done <= '0;
        end else begin
            case (state)
                IDLE: ;
                WAIT: begin
                    if (lat_cnt <= 4'd1) begin
                        state    <= BURST;
                        rvalid_q <= 1'b1;
                        rdata_q  <= beat_data(cur_addr, 8'd0, cur_err, pattern_mode);
                        rlast_q  <= (cur_len == 8'd0);
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                BURST: begin
                    if (hs) begin
                        if (rlast_q) begin
                            bursts_done <= bursts_done + 16'd1;
                            rvalid_q    <= 1'b0;
                            rlast_q     <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            beat     <= beat_nxt;
                            cur_addr <= addr_nxt;
                            rdata_q  <= beat_data(addr_nxt, beat_nxt, cur_err, pattern_mode);
                            rlast_q  <= (beat_nxt == cur_len);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // A pop loads the next burst and overrides the state chosen above.
            if (pop) begin
                beat      <= '0;
                cur_len   <= head.len;
                cur_addr  <= head.addr;
                cur_size  <= head.size;
                cur_burst <= head.burst;
                cur_err   <= head_err;
                rid_q     <= head.id;
                rresp_q   <= head_err ? 2'b10 : 2'b00;
                if (FIRST_BEAT_LATENCY == 0) begin
                    state    <= BURST;
                    rvalid_q <= 1'b1;
                    rdata_q  <= beat_data(head.addr, 8'd0, head_err, pattern_mode);
                    rlast_q  <= (head.len == 8'd0);
                end else begin
                    state    <= WAIT;
                    lat_cnt  <= 4'(FIRST_BEAT_LATENCY);
                    rvalid_q <= 1'b0;
                    rlast_q  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_dc_axi_pattern_read_slave.sv
// Directed bench for dc_axi_pattern_read_slave: latency, data patterns, stalls, queueing,
// error responses, mid-burst reset and en gating.
module tb_dc_axi_pattern_read_slave;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  pattern_mode = 2'd0;
    logic        busy;
    logic [15:0] bursts_done;
    int          checks = 0;
    int          failures = 0;

    dc_axi_pattern_read_slave_if #(.AW(32), .DW(16), .IW(8)) axi ();

    dc_axi_pattern_read_slave #(
        .AXI_ARADDR_WIDTH(32), .AXI_DATA_WIDTH(16), .AXI_ID_WIDTH(8),
        .AR_QUEUE_DEPTH(2), .FIRST_BEAT_LATENCY(2)
    ) dut (
        .clk(clk), .nrst(nrst), .en(en), .pattern_mode(pattern_mode),
        .axi(axi), .busy(busy), .bursts_done(bursts_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic ok;
        ok = 1'b0;
        axi.arid = id; axi.araddr = addr; axi.arlen = len;
        axi.arsize = size; axi.arburst = burst; axi.arvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (axi.arready === 1'b1) begin
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
        axi.arvalid = 1'b0;
        chk("ar_accepted", 32'(ok), 32'd1);
    endtask

    task automatic get_beat(output logic [7:0] rid, output logic [15:0] rdata,
                            output logic [1:0] rresp, output logic rlast);
        logic ok;
        ok = 1'b0;
        rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
        axi.rready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (axi.rvalid === 1'b1) begin
                rid = axi.rid; rdata = axi.rdata; rresp = axi.rresp; rlast = axi.rlast;
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("beat_seen", 32'(ok), 32'd1);
    endtask

    initial begin
        logic [7:0]  rid;
        logic [15:0] rd;
        logic [1:0]  rr;
        logic        rl;
        int          k;
        bit          pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0;
        axi.arburst = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
        en = 1'b1;

        // Reset state
        step(); step();
        chk("rst_rvalid", 32'(axi.rvalid), 32'd0);
        chk("rst_arready", 32'(axi.arready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(bursts_done), 32'd0);
        nrst = 1'b1;
        #1;
        chk("arready_before_clk", 32'(axi.arready), 32'd0);
        step();
        chk("arready_after_clk", 32'(axi.arready), 32'd1);

        // 1) INCR len=3 at 0x100, latency 3 cycles after AR handshake
        axi.rready = 1'b1;
        send_ar(8'd0, 32'h100, 8'd3, 3'd1, 2'b01);
        chk("t1_lat0", 32'(axi.rvalid), 32'd0);
        step();
        chk("t1_lat1", 32'(axi.rvalid), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        step();
        chk("t1_lat2", 32'(axi.rvalid), 32'd0);
        step();
        chk("t1_lat3", 32'(axi.rvalid), 32'd1);
        for (int b = 0; b < 4; b++) begin
            chk("t1_data", 32'(axi.rdata), 32'h80 + 32'(b));
            chk("t1_last", 32'(axi.rlast), (b == 3) ? 32'd1 : 32'd0);
            chk("t1_rvalid", 32'(axi.rvalid), 32'd1);
            step();
        end
        chk("t1_end_rvalid", 32'(axi.rvalid), 32'd0);
        chk("t1_done", 32'(bursts_done), 32'd1);
        chk("t1_idle", 32'(busy), 32'd0);

        // 2) len=7 with rready pattern 1,0,0,1
        axi.rready = 1'b0;
        send_ar(8'd5, 32'h200, 8'd7, 3'd1, 2'b01);
        k = 0;
        for (int i = 0; i < 100 && k < 8; i++) begin
            axi.rready = pat[i % 4];
            if (axi.rvalid === 1'b1) begin
                chk("t2_data", 32'(axi.rdata), 32'h100 + 32'(k));
                chk("t2_last", 32'(axi.rlast), (k == 7) ? 32'd1 : 32'd0);
                if (axi.rready) k++;
            end
            step();
        end
        chk("t2_beats", 32'(k), 32'd8);
        chk("t2_done", 32'(bursts_done), 32'd2);

        // 3) three requests with rready low: one active, two queued, then full
        axi.rready = 1'b0;
        send_ar(8'd1, 32'h300, 8'd0, 3'd1, 2'b01);
        send_ar(8'd2, 32'h302, 8'd0, 3'd1, 2'b01);
        send_ar(8'd3, 32'h304, 8'd0, 3'd1, 2'b01);
        chk("t3_full_arready", 32'(axi.arready), 32'd0);
        chk("t3_busy", 32'(busy), 32'd1);
        for (int n = 0; n < 3; n++) begin
            get_beat(rid, rd, rr, rl);
            chk("t3_rid", 32'(rid), 32'd1 + 32'(n));
            chk("t3_data", 32'(rd), 32'h180 + 32'(n));
            chk("t3_last", 32'(rl), 32'd1);
            if (n == 0) chk("t3_arready_freed", 32'(axi.arready), 32'd1);
        end
        chk("t3_done", 32'(bursts_done), 32'd5);

        // 4) FIXED with inverted pattern, then reserved burst and oversized beat
        pattern_mode = 2'd1;
        send_ar(8'd7, 32'h40, 8'd2, 3'd1, 2'b00);
        for (int b = 0; b < 3; b++) begin
            get_beat(rid, rd, rr, rl);
            chk("t4_fixed_data", 32'(rd), 32'hFFDF);
            chk("t4_fixed_resp", 32'(rr), 32'd0);
            chk("t4_fixed_last", 32'(rl), (b == 2) ? 32'd1 : 32'd0);
        end
        send_ar(8'd8, 32'h40, 8'd1, 3'd1, 2'b11);
        for (int b = 0; b < 2; b++) begin
            get_beat(rid, rd, rr, rl);
            chk("t4_err_data", 32'(rd), 32'd0);
            chk("t4_err_resp", 32'(rr), 32'd2);
            chk("t4_err_last", 32'(rl), (b == 1) ? 32'd1 : 32'd0);
        end
        send_ar(8'd9, 32'h40, 8'd0, 3'd2, 2'b01);
        get_beat(rid, rd, rr, rl);
        chk("t4_size_resp", 32'(rr), 32'd2);
        chk("t4_size_data", 32'(rd), 32'd0);
        chk("t4_done", 32'(bursts_done), 32'd8);
        pattern_mode = 2'd0;

        // 5) reset during beat 2 of a queued pair
        axi.rready = 1'b0;
        send_ar(8'd10, 32'h600, 8'd3, 3'd1, 2'b01);
        send_ar(8'd11, 32'h700, 8'd3, 3'd1, 2'b01);
        get_beat(rid, rd, rr, rl);
        chk("t5_beat0", 32'(rd), 32'h300);
        get_beat(rid, rd, rr, rl);
        chk("t5_beat1", 32'(rd), 32'h301);
        chk("t5_beat2_valid", 32'(axi.rvalid), 32'd1);
        nrst = 1'b0;
        #1;
        chk("t5_rst_rvalid", 32'(axi.rvalid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(bursts_done), 32'd0);
        step();
        nrst = 1'b1;
        step(); step(); step(); step();
        chk("t5_no_beats", 32'(axi.rvalid), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);
        send_ar(8'd12, 32'h500, 8'd0, 3'd1, 2'b01);
        get_beat(rid, rd, rr, rl);
        chk("t5_new_rid", 32'(rid), 32'd12);
        chk("t5_new_data", 32'(rd), 32'h280);
        chk("t5_new_last", 32'(rl), 32'd1);
        chk("t5_new_done", 32'(bursts_done), 32'd1);

        // 6) en dropped mid-burst; beat-index pattern
        axi.rready = 1'b0;
        pattern_mode = 2'd2;
        send_ar(8'd13, 32'h800, 8'd3, 3'd1, 2'b01);
        for (int i = 0; i < 20 && axi.rvalid !== 1'b1; i++) step();
        chk("t6_active", 32'(axi.rvalid), 32'd1);
        en = 1'b0;
        #1;
        chk("t6_arready_off", 32'(axi.arready), 32'd0);
        for (int b = 0; b < 4; b++) begin
            get_beat(rid, rd, rr, rl);
            chk("t6_data", 32'(rd), 32'(b));
            chk("t6_last", 32'(rl), (b == 3) ? 32'd1 : 32'd0);
        end
        step();
        chk("t6_arready_still_off", 32'(axi.arready), 32'd0);
        chk("t6_done", 32'(bursts_done), 32'd2);
        chk("t6_idle", 32'(busy), 32'd0);
        en = 1'b1;
        #1;
        chk("t6_arready_on", 32'(axi.arready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
